fetch_instr_queue: RTL

Parametrised instruction queue between the fetch stage and decode. It takes up to `WIDTH` fetched instruction lanes per cycle and compacts out the invalid lanes. It buffers up to `DEPTH` entries in program order and presents the oldest `WIDTH` entries to decode, which dequeues 0..`WIDTH` of them per cycle. It generalises the fixed 2-wide, unbuffered fetch output to any width, and decouples I-cache stalls from decode stalls.

---
 rtl/fetch_instr_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_instr_queue.sv
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

// ============================================================================
// Module   : fetch_instr_queue
// Purpose  : Compacting, multi-lane instruction queue between fetch and
//            decode. Accepts up to WIDTH fetched lanes per cycle, squeezes
//            out invalid lanes, buffers DEPTH entries in program order and
//            presents the oldest WIDTH entries to decode.
// Ports    : clk, reset (sync, active-high), flush
//            in_valid/in_pc/in_instr/in_prediction/in_guesses_branch : fetch
//            in_ready        : room for a full WIDTH-lane bundle
//            out_valid/out_pc/out_instr/out_prediction/out_guesses_branch
//                            : oldest entries, lane 0 = oldest
//            deq_count       : lanes consumed by decode this cycle
//            occupancy       : registered entry count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_instr_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int AW    = `ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH*AW-1:0]           in_pc,
    input  logic [WIDTH*32-1:0]           in_instr,
    input  logic [WIDTH*AW-1:0]           in_prediction,
    input  logic [WIDTH-1:0]              in_guesses_branch,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_valid,
    output logic [WIDTH*AW-1:0]           out_pc,
    output logic [WIDTH*32-1:0]           out_instr,
    output logic [WIDTH*AW-1:0]           out_prediction,
    output logic [WIDTH-1:0]              out_guesses_branch,
    input  logic [$clog2(WIDTH+1)-1:0]    deq_count,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int c_pw = $clog2(DEPTH);       // pointer width
    localparam int c_ow = $clog2(DEPTH+1);     // occupancy width
    localparam int c_cw = $clog2(WIDTH+1);     // per-cycle lane count width

    // Illegal geometry must stop elaboration rather than build a broken queue.
    generate
        if (WIDTH < 1 || DEPTH < 2*WIDTH || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_params
            $error("fetch_instr_queue: DEPTH must be a power of two >= 2*WIDTH, WIDTH >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_pw-1:0] r_head;
    logic [c_pw-1:0] r_tail;
    logic [c_ow-1:0] r_occ;

    // Payload storage is intentionally not reset.
    logic [AW-1:0]   r_pc    [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic [AW-1:0]   r_pred  [DEPTH];
    logic            r_gb    [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [c_ow-1:0] w_free;
    logic            w_enq;
    logic [c_cw-1:0] w_nenq;
    logic [c_cw-1:0] w_nenq_eff;
    logic [c_cw-1:0] w_lane_off [WIDTH];
    logic [c_pw-1:0] w_wr_slot  [WIDTH];
    logic [c_cw-1:0] w_deq_req;
    logic [c_ow-1:0] w_ndeq;

    // Readiness looks only at registered occupancy, so decode's dequeue
    // never feeds combinationally back into fetch.
    assign w_free   = c_ow'(DEPTH) - r_occ;
    assign in_ready = (w_free >= c_ow'(WIDTH));
    assign w_enq    = in_ready && (|in_valid) && !flush;

    // Compaction: each valid lane lands at tail + (number of valid lanes
    // below it), so valid lanes pack densely in ascending lane order.
    always_comb begin
        w_nenq = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_lane_off[i] = w_nenq;
            w_wr_slot[i]  = r_tail + c_pw'(w_nenq);
            if (in_valid[i]) begin
                w_nenq = w_nenq + c_cw'(1);
            end
        end
    end

    assign w_nenq_eff = w_enq ? w_nenq : '0;

    // Requests beyond WIDTH or beyond what is buffered are clamped.
    assign w_deq_req = (deq_count > c_cw'(WIDTH)) ? c_cw'(WIDTH) : deq_count;
    assign w_ndeq    = (c_ow'(w_deq_req) > r_occ) ? r_occ : c_ow'(w_deq_req);

    // ------------------------------------------------------------------
    // Pointers and occupancy (reset outranks flush; both empty the queue)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + c_pw'(w_ndeq);
            r_tail <= r_tail + c_pw'(w_nenq_eff);
            r_occ  <= r_occ + c_ow'(w_nenq_eff) - w_ndeq;
        end
    end

    // ------------------------------------------------------------------
    // Payload write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_valid[i]) begin
                    r_pc[w_wr_slot[i]]    <= in_pc[i*AW +: AW];
                    r_instr[w_wr_slot[i]] <= in_instr[i*32 +: 32];
                    r_pred[w_wr_slot[i]]  <= in_prediction[i*AW +: AW];
                    r_gb[w_wr_slot[i]]    <= in_guesses_branch[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output lanes: lane i shows entry head+i, valid when occupancy > i
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_out
            logic [c_pw-1:0] w_rd_slot;
            assign w_rd_slot                   = r_head + c_pw'(i);
            assign out_valid[i]                = (r_occ > c_ow'(i));
            assign out_pc[i*AW +: AW]          = r_pc[w_rd_slot];
            assign out_instr[i*32 +: 32]       = r_instr[w_rd_slot];
            assign out_prediction[i*AW +: AW]  = r_pred[w_rd_slot];
            assign out_guesses_branch[i]       = r_gb[w_rd_slot];
        end
    endgenerate

    assign occupancy = r_occ;

endmodule

`default_nettype wire
